// File: rtl/demux4_rr_dispatcher_pkg.sv
// Shared constants and the rotating first-set search used by the
// round-robin dispatcher.
package demux_pkg;

    localparam int NCH  = 4;
    localparam int SELW = 2;

    // Returns {found, idx}: first set bit of mask scanning ptr, ptr+1, ... mod NCH
    function automatic logic [SELW:0] rr_next(input logic [SELW-1:0] ptr,
                                              input logic [NCH-1:0]  mask);
        logic [SELW:0]   result;
        logic [SELW-1:0] idx;
        result = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = ptr + SELW'(k);
            if (mask[idx]) begin
                result = {1'b1, idx};
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/demux4_rr_dispatcher_rr_pick4.sv
// Combinational rotating first-set finder over a 4-bit mask,
// starting the search at ptr.
module rr_pick4
    import demux_pkg::*;
(
    input  logic [SELW-1:0] ptr,
    input  logic [NCH-1:0]  mask,
    output logic            found,
    output logic [SELW-1:0] idx
);

    logic [SELW:0] pick;

    always_comb begin
        pick  = rr_next(ptr, mask);
        found = pick[SELW];
        idx   = pick[SELW-1:0];
    end

endmodule

// File: rtl/demux4_rr_dispatcher.sv
// Round-robin 1-to-4 dispatcher: a one-entry holding register feeds one of
// four valid/ready channels and drives the demux select pair from it.
module demux4_rr_dispatcher
    import demux_pkg::*;
#(
    parameter int DW            = 8,
    parameter bit SKIP_DISABLED = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NCH-1:0]  en,
    input  logic            in_valid,
    input  logic [DW-1:0]   in_data,
    output logic            in_ready,
    output logic [DW-1:0]   out_data,
    output logic [NCH-1:0]  out_valid,
    input  logic [NCH-1:0]  out_ready,
    output logic            s1,
    output logic            s0,
    output logic            busy
);

    logic            hold_valid;
    logic [DW-1:0]   hold_data;
    logic [SELW-1:0] sel;
    logic [SELW-1:0] ptr;

    logic            pick_found;
    logic [SELW-1:0] pick_idx;
    logic            cand_found;
    logic [SELW-1:0] cand_idx;
    logic            fire;
    logic            accept;

    rr_pick4 u_pick (
        .ptr   (ptr),
        .mask  (en),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Strict rotation only offers ptr itself and stalls while it is disabled
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = ptr;
        if (SKIP_DISABLED) begin
            cand_found = pick_found;
            cand_idx   = pick_idx;
        end else begin
            cand_found = en[ptr];
        end
    end

    // A word may enter in the same cycle the held word leaves
    always_comb begin
        fire     = hold_valid & out_ready[sel];
        in_ready = cand_found & (~hold_valid | fire);
        accept   = in_valid & in_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
            sel        <= '0;
            ptr        <= '0;
        end else if (accept) begin
            hold_valid <= 1'b1;
            hold_data  <= in_data;
            sel        <= cand_idx;
            ptr        <= cand_idx + 1'b1;
        end else if (fire) begin
            hold_valid <= 1'b0;
        end
    end

    // Outputs decode registered state only, so out_ready never reaches out_valid
    always_comb begin
        out_valid = '0;
        if (hold_valid) begin
            out_valid[sel] = 1'b1;
        end
        out_data = hold_data;
        s1       = sel[1];
        s0       = sel[0];
        busy     = hold_valid;
    end

endmodule

// File: tb/tb_demux4_rr_dispatcher.sv
// Scoreboard bench for demux4_rr_dispatcher: directed scenarios plus random
// traffic checked against a queue-based round-robin reference model.
module tb_demux4_rr_dispatcher;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] en;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [7:0] out_data;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic       s1;
    logic       s0;
    logic       busy;

    logic [3:0] s_en;
    logic       s_in_valid;
    logic [7:0] s_in_data;
    logic       s_in_ready;
    logic [7:0] s_out_data;
    logic [3:0] s_out_valid;
    logic [3:0] s_out_ready;
    logic       s_s1;
    logic       s_s0;
    logic       s_busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: held flag, latched channel, next search start
    bit m_hold;
    int m_sel;
    int m_ptr;

    typedef struct {
        int         chan;
        logic [7:0] data;
    } word_t;
    word_t sb[$];

    always #5 clk = ~clk;

    demux4_rr_dispatcher #(.DW(8), .SKIP_DISABLED(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s1        (s1),
        .s0        (s0),
        .busy      (busy)
    );

    demux4_rr_dispatcher #(.DW(8), .SKIP_DISABLED(1'b0)) dut_strict (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (s_en),
        .in_valid  (s_in_valid),
        .in_data   (s_in_data),
        .in_ready  (s_in_ready),
        .out_data  (s_out_data),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .s1        (s_s1),
        .s0        (s_s0),
        .busy      (s_busy)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, compare combinational outputs, advance model
    task automatic apply_stimulus(input logic v, input logic [7:0] d,
                                  input logic [3:0] e, input logic [3:0] r);
        bit found;
        int cand;
        bit m_fire;
        bit exp_ready;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        en        = e;
        out_ready = r;
        #1;
        found = 0;
        cand  = 0;
        for (int k = 0; k < 4; k++) begin
            if (!found && e[(m_ptr + k) % 4]) begin
                found = 1;
                cand  = (m_ptr + k) % 4;
            end
        end
        m_fire    = m_hold && r[m_sel];
        exp_ready = found && (!m_hold || m_fire);
        check_output("in_ready", in_ready, exp_ready);
        check_output("busy", busy, m_hold);
        check_output("out_valid", out_valid, m_hold ? (32'd1 << m_sel) : 32'd0);
        if (v && exp_ready) begin
            sb.push_back('{chan: cand, data: d});
            m_hold = 1;
            m_sel  = cand;
            m_ptr  = (cand + 1) % 4;
        end else if (m_fire) begin
            m_hold = 0;
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        sb.delete();
        m_hold = 0;
        m_sel  = 0;
        m_ptr  = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_output("rst_busy", busy, 0);
        check_output("rst_out_valid", out_valid, 0);
        check_output("rst_sel", {s1, s0}, 0);
    endtask

    // Monitor: every delivered word must be the oldest expected one
    initial begin
        word_t w;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (busy && sb.size() > 0) begin
                    check_output("stable_data", out_data, sb[0].data);
                end
                for (int k = 0; k < 4; k++) begin
                    if (out_valid[k] && out_ready[k]) begin
                        if (sb.size() == 0) begin
                            check_output("unexpected_word", 1, 0);
                        end else begin
                            w = sb.pop_front();
                            check_output("chan", k, w.chan);
                            check_output("data", out_data, w.data);
                            check_output("select", {s1, s0}, w.chan);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] cur_en;
        rst_n      = 1'b0;
        en         = 4'b1111;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        out_ready  = 4'b0000;
        s_en       = 4'b0000;
        s_in_valid = 1'b0;
        s_in_data  = 8'h3C;
        s_out_ready = 4'b1111;
        repeat (2) @(posedge clk);
        do_reset();
        check_output("rst_out_data", out_data, 0);
        check_output("rst_in_ready", in_ready, 1);

        // Strict rotation stalls on a disabled pointer channel
        @(negedge clk);
        s_en = 4'b1110; s_in_valid = 1'b1;
        #1 check_output("strict_ready_blocked", s_in_ready, 0);
        @(negedge clk);
        s_en = 4'b0001;
        #1 check_output("strict_ready_open", s_in_ready, 1);
        @(negedge clk);
        s_in_valid = 1'b0;
        #1 check_output("strict_out_valid", s_out_valid, 4'b0001);
        check_output("strict_ptr1_blocked", s_in_ready, 0);
        @(negedge clk);
        s_en = 4'b0010;
        #1 check_output("strict_ptr1_open", s_in_ready, 1);
        check_output("strict_drained", s_out_valid, 0);

        // Basic rotation
        foreach (sb[i]) begin end
        for (int i = 1; i <= 5; i++) apply_stimulus(1, 8'(i * 8'h11), 4'b1111, 4'b1111);
        apply_stimulus(0, 8'h00, 4'b1111, 4'b1111);

        // Skip disabled channels: 1, 3, 1, 3
        for (int i = 0; i < 4; i++) apply_stimulus(1, 8'(8'h60 + i), 4'b1010, 4'b1111);
        apply_stimulus(0, 8'h00, 4'b1010, 4'b1111);

        // Backpressure on channel 0, new word accepted on the draining cycle
        apply_stimulus(1, 8'hA5, 4'b0001, 4'b1111);
        for (int i = 0; i < 3; i++) apply_stimulus(1, 8'h5A, 4'b0001, 4'b1110);
        apply_stimulus(1, 8'h5A, 4'b0001, 4'b0001);
        apply_stimulus(0, 8'h00, 4'b0001, 4'b1111);

        // Enable drop while holding on channel 2
        apply_stimulus(1, 8'hC2, 4'b0100, 4'b1111);
        apply_stimulus(0, 8'h00, 4'b1011, 4'b0000);
        apply_stimulus(0, 8'h00, 4'b1011, 4'b1111);
        apply_stimulus(1, 8'hC3, 4'b1011, 4'b1111);
        apply_stimulus(0, 8'h00, 4'b1011, 4'b1111);

        // No enables
        for (int i = 0; i < 2; i++) apply_stimulus(1, 8'hEE, 4'b0000, 4'b1111);

        // Reset mid-operation with a word held and ptr=2
        do_reset();
        apply_stimulus(1, 8'h01, 4'b1111, 4'b1111);
        apply_stimulus(1, 8'h02, 4'b1111, 4'b1111);
        apply_stimulus(0, 8'h00, 4'b1111, 4'b0000);
        do_reset();
        apply_stimulus(1, 8'h03, 4'b1111, 4'b1111);
        apply_stimulus(0, 8'h00, 4'b1111, 4'b1111);

        // Random traffic with occasional enable changes
        cur_en = 4'b1111;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) cur_en = 4'($urandom);
            apply_stimulus(($urandom_range(0, 3) != 0), 8'($urandom), cur_en,
                           4'($urandom) | 4'($urandom));
        end
        for (int i = 0; i < 4; i++) apply_stimulus(0, 8'h00, cur_en, 4'b1111);
        check_output("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
